// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and default framing.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Bundle of the receiver's line, tick and byte-handshake signals.
interface uart_receiver_if import uart_pkg::*; #(
  parameter int unsigned DATA_BITS = UART_DATA_BITS
) ();

  logic                 rxclk_en;
  logic                 rx;
  logic                 rdy_clr;
  logic [DATA_BITS-1:0] data;
  logic                 rdy;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rxclk_en, rx, rdy_clr,
    input  data, rdy, frame_err, overrun
  );

  modport slave (
    input  rxclk_en, rx, rdy_clr,
    output data, rdy, frame_err, overrun
  );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start-bit qualification, mid-bit sampling,
// single-byte holding register with sticky framing/overrun flags.
module uart_receiver import uart_pkg::*; #(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 rxclk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_state_e          state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [IDX_W-1:0]     idx_q,       idx_d;
  logic [DATA_BITS-1:0] shreg_q,     shreg_d;
  logic                 armed_q,     armed_d;
  logic [DATA_BITS-1:0] data_q,      data_d;
  logic                 rdy_q,       rdy_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q,   overrun_d;

  logic stop_good;
  logic stop_bad;

  uart_sync u_sync (
    .clk   (clk_50m),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    armed_d     = armed_q;
    data_d      = data_q;
    rdy_d       = rdy_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    stop_good   = 1'b0;
    stop_bad    = 1'b0;

    if (rxclk_en) begin
      unique case (state_q)
        // After a framing error the line must be seen high again before a
        // new start bit is accepted, so a held break yields a single error.
        IDLE: begin
          cnt_d = '0;
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = START;
            cnt_d   = CNT_ONE;
          end
        end
        START: begin
          if (rx_s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_HALF) begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST) begin
              state_d = STOP;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (rx_s) begin
              stop_good = 1'b1;
            end else begin
              stop_bad = 1'b1;
              armed_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      endcase
    end

    // A consumer acknowledge in the completion cycle frees the holding
    // register for the new byte and clears both sticky flags.
    if (stop_good) begin
      if (!rdy_q || rdy_clr) begin
        data_d = shreg_q;
        rdy_d  = 1'b1;
        if (rdy_clr) begin
          frame_err_d = 1'b0;
          overrun_d   = 1'b0;
        end
      end else begin
        overrun_d = 1'b1;
      end
    end else if (stop_bad) begin
      frame_err_d = 1'b1;
      if (rdy_clr) begin
        rdy_d     = 1'b0;
        overrun_d = 1'b0;
      end
    end else if (rdy_clr) begin
      rdy_d       = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      armed_q     <= 1'b1;
      data_q      <= '0;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      armed_q     <= armed_d;
      data_q      <= data_d;
      rdy_q       <= rdy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign rdy       = rdy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16: rxclk_en ticks per bit period.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame.
REQ-003 SHALL have port clk_50m, input, 1, the single clock; all flops clock on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rxclk_en, input, 1, single-cycle oversample enable at OVERSAMPLE x baud.
REQ-006 SHALL have port rx, input, 1, asynchronous serial line; idle high.
REQ-007 SHALL have port rdy_clr, input, 1, single-cycle consumer acknowledge of the held byte.
REQ-008 SHALL have port data, output, DATA_BITS, last accepted byte.
REQ-009 SHALL have port rdy, output, 1, a byte is held and unacknowledged.
REQ-010 SHALL have port frame_err, output, 1, sticky: stop bit sampled low.
REQ-011 SHALL have port overrun, output, 1, sticky: a byte completed while rdy=1.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer before any use; the FSM sees only rx_s.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP; tick counter cnt is clog2(OVERSAMPLE) bits; bit index is clog2(DATA_BITS) bits.
REQ-014 SHALL advance FSM state and cnt only in cycles with rxclk_en=1; with rxclk_en=0 all state holds.
REQ-015 IDLE: on a tick with rx_s=0, go to START with cnt=1; else stay, cnt=0.
REQ-016 START: on each tick, if rx_s=1 return to IDLE (glitch reject); else if cnt=OVERSAMPLE/2-1, go to DATA with cnt=0, index=0; else cnt+1.
REQ-017 DATA: on each tick, cnt+1; when cnt=OVERSAMPLE-1, shift rx_s into the shift register LSB-first, cnt wraps to 0, index+1; after bit DATA_BITS-1 go to STOP.
REQ-018 STOP: on the tick with cnt=OVERSAMPLE-1, sample rx_s and go to IDLE; rx_s=1 is a good frame, rx_s=0 is a framing error.
REQ-019 Good frame with rdy=0 or rdy_clr=1 in that cycle: load data, set rdy=1, the cycle after the stop-sampling tick.
REQ-020 Good frame with rdy=1 and rdy_clr=0: data unchanged, rdy stays 1, overrun set to 1.
REQ-021 Framing error: data and rdy unchanged, frame_err set to 1.
REQ-022 rdy_clr=1 with no completing frame: clears rdy, frame_err and overrun the next cycle; rdy_clr with rdy=0 is harmless.
REQ-023 A good-frame completion coincident with rdy_clr: the new byte loads, rdy stays 1, overrun and frame_err clear.
REQ-024 SHALL recover from a line held low (break): after the framing error, stay in IDLE->START until rx_s returns high.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, cnt=0, index=0, shift register=0, synchronizer flops=1, data=0, rdy=0, frame_err=0, overrun=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial byte; after release, reception begins with the next falling edge of rx.

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state enum and the OVERSAMPLE/DATA_BITS defaults, shared with the future transmitter.
REQ-028 SHALL instantiate one sub-module, uart_sync (2-flop synchronizer, reset value 1); all other logic stays in uart_receiver.

Verification
REQ-029 Send frame 0x55 at 115200 baud, with rxclk_en from the baud generator -> data=0x55, rdy=1, frame_err=0, overrun=0.
REQ-030 Send 0xA3; pulse rdy_clr -> rdy=0 the next cycle; send 0x3C -> data=0x3C, rdy=1.
REQ-031 Drive rx low for 4 ticks, then high -> FSM returns to IDLE, rdy stays 0, no byte loaded.
REQ-032 Send 0x81 with the stop bit low -> frame_err=1, rdy=0, data unchanged.
REQ-033 Send 0x11 then 0x22 without rdy_clr -> data=0x11, rdy=1, overrun=1; repeat with rdy_clr on the completion cycle -> data=0x22, overrun=0.
REQ-034 Assert rst_n=0 during bit 3 of 0xF0 -> all outputs 0 at once; a following frame 0x0F -> data=0x0F.
